alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined ALU with an architectural NZCV flag register.
//
// Stage S1 registers the operands, carry-in, opcode and flags_en.  The ALU
// evaluates combinationally from S1 and its result and flags load into S2.
// S2 registers drive the outputs directly.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high (in_valid/in_ready on the input side, out_valid/out_ready on
// the output side).  A producer holds its payload stable while valid is high
// and ready is low.  in_ready never depends on in_valid.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; discards every in-flight op
//   in_valid   operands/opcode present
//   in_ready   block accepts operands this cycle
//   a, b       WIDTH-bit operands
//   cin        carry-in for opcodes 0010/0011
//   S          4-bit opcode
//   flags_en   this op updates the flags
//   out_valid  result present
//   out_ready  consumer takes the result
//   d          WIDTH-bit result
//   n, z, c, v per-result flags (0 when the op had flags_en=0)
//   nzcv       architectural flag register {N,Z,C,V}
//
// WIDTH must be a power of two between 8 and 128.

module alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       S,
    input  logic             flags_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic [3:0]       nzcv
);

    localparam int LOG = $clog2(WIDTH);

    localparam logic [3:0] OP_XOR  = 4'b0000;
    localparam logic [3:0] OP_XNB  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_ZERO = 4'b0111;
    localparam logic [3:0] OP_LSL  = 4'b1000;
    localparam logic [3:0] OP_LSR  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_ADC  = 4'b1011;
    localparam logic [3:0] OP_SBC  = 4'b1100;
    localparam logic [3:0] OP_PASS = 4'b1101;

    // Kogge-Stone prefix carry network: LOG levels of (G,P) combination.
    // Returns the carry into every bit plus the final carry-out in bit WIDTH.
    function automatic logic [WIDTH:0] cla_carries(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             ci
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g_nx;
        logic [WIDTH-1:0] p_nx;
        logic [WIDTH:0]   cy;
        g = x & y;
        p = x ^ y;
        for (int l = 0; l < LOG; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    g_nx[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p_nx[i] = p[i] & p[i - (1 << l)];
                end else begin
                    g_nx[i] = g[i];
                    p_nx[i] = p[i];
                end
            end
            g = g_nx;
            p = p_nx;
        end
        cy[0] = ci;
        for (int i = 0; i < WIDTH; i++) begin
            cy[i+1] = g[i] | (p[i] & ci);
        end
        return cy;
    endfunction

    // ---------------- S1 ----------------
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [3:0]       s1_op;
    logic             s1_fe;

    logic s2_load;
    logic accept;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = (!s1_valid || s2_load) && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_op    <= '0;
            s1_fe    <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_cin   <= cin;
            s1_op    <= S;
            s1_fe    <= flags_en;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // ---------------- ALU (from S1) ----------------
    logic [WIDTH-1:0] add_y;
    logic             add_ci;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [LOG-1:0]   sh;
    logic [LOG-1:0]   sh_neg;
    logic [LOG-1:0]   sh_m1;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_n;
    logic             res_z;

    always_comb begin
        add_y  = s1_b;
        add_ci = s1_cin;
        if (s1_op == OP_SUB || s1_op == OP_SBC) begin
            add_y = ~s1_b;
        end
        // ADC/SBC take the carry from the flag register as it stands now, so
        // an immediately preceding flag-setting op (loaded last edge) is seen.
        if (s1_op == OP_ADC || s1_op == OP_SBC) begin
            add_ci = nzcv[1];
        end
        carry = cla_carries(s1_a, add_y, add_ci);
        sum   = s1_a ^ add_y ^ carry[WIDTH-1:0];

        sh     = s1_b[LOG-1:0];
        sh_neg = LOG'(0) - sh;     // WIDTH - sh, for sh != 0
        sh_m1  = sh - LOG'(1);

        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (s1_op)
            OP_XOR:  res = s1_a ^ s1_b;
            OP_XNB:  res = s1_a ^ ~s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_NOR:  res = ~(s1_a | s1_b);
            OP_AND:  res = s1_a & s1_b;
            OP_ZERO: res = '0;
            OP_PASS: res = s1_b;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res   = sum;
                res_c = carry[WIDTH];
                res_v = carry[WIDTH] ^ carry[WIDTH-1];
            end
            OP_LSL: begin
                res   = s1_a << sh;
                res_c = (sh != '0) ? s1_a[sh_neg] : 1'b0;
            end
            OP_LSR: begin
                res   = s1_a >> sh;
                res_c = (sh != '0) ? s1_a[sh_m1] : 1'b0;
            end
            OP_ASR: begin
                res   = $signed(s1_a) >>> sh;
                res_c = (sh != '0) ? s1_a[sh_m1] : 1'b0;
            end
            default: res = '0;
        endcase
        res_n = res[WIDTH-1];
        res_z = (res == '0);
    end

    // ---------------- S2 and flag register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            d         <= '0;
            n         <= 1'b0;
            z         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            nzcv      <= 4'b0000;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            d         <= res;
            n         <= s1_fe & res_n;
            z         <= s1_fe & res_z;
            c         <= s1_fe & res_c;
            v         <= s1_fe & res_v;
            if (s1_fe) begin
                nzcv <= {res_n, res_z, res_c, res_v};
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- directed-vector bench for alu_pipe (WIDTH=64).
// The driver pushes each hand-computed expected response {d, nzcv-flags,
// nzcv register} into exp_q when the op is accepted; an independent monitor
// pops and compares whenever a result transfers out.

module tb_alu_pipe;

    localparam int W  = 64;
    localparam int EW = W + 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   S;
    logic         flags_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
    logic [3:0]   nzcv;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .S         (S),
        .flags_en  (flags_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .nzcv      (nzcv)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            stall_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin, input logic vfe,
                        input logic [W-1:0] ed, input logic [3:0] ef, input logic [3:0] en);
        int t;
        in_valid = 1'b1;
        S        = op;
        a        = va;
        b        = vb;
        cin      = vcin;
        flags_en = vfe;
        #1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        stall_cnt += t;
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept op=%0h", op);
        end else begin
            exp_q.push_back({ed, ef, en});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_size", 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- monitor ----------------
    logic          hold_prev = 1'b0;
    logic [W+3:0]  hold_val;
    logic [EW-1:0] e;

    always begin
        @(negedge clk);
        #2;
        if (!reset && out_valid) begin
            if (hold_prev) begin
                chk("hold_stable", {d, n, z, c, v}, hold_val);
            end
            if (out_ready) begin
                hold_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=no_output", d);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_d", d, e[EW-1:8]);
                    chk("result_nzcv_flags", {n, z, c, v}, e[7:4]);
                    chk("flag_register", nzcv, e[3:0]);
                end
            end else begin
                hold_prev = 1'b1;
                hold_val  = {d, n, z, c, v};
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        S         = 4'b0000;
        flags_en  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_d", d, '0);
        chk("reset_flags", {n, z, c, v}, 4'b0000);
        chk("reset_nzcv", nzcv, 4'b0000);
        reset = 1'b0;
        @(negedge clk);

        // Latency: presented in cycle 0, result visible in cycle 2.
        send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'd0, 4'b0110, 4'b0110);
        #1;
        chk("latency_cycle1_out_valid", out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("latency_cycle2_out_valid", out_valid, 1'b1);

        // Back-to-back stream, no backpressure.
        stall_cnt = 0;
        send(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 4'b1001, 4'b1001);
        send(4'b1011, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 4'b0100, 4'b0100);
        send(4'b1010, 64'h8000_0000_0000_0001, 64'h41, 1'b0, 1'b1, 64'hC000_0000_0000_0000, 4'b1010, 4'b1010);
        send(4'b1011, 64'd5, 64'd6, 1'b0, 1'b0, 64'd12, 4'b0000, 4'b1010);
        send(4'b1100, 64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 4'b0010, 4'b0010);
        send(4'b0011, 64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'b1000);
        send(4'b0000, 64'hF0F0, 64'hFF00, 1'b0, 1'b1, 64'h0FF0, 4'b0000, 4'b0000);
        send(4'b0001, 64'd0, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b1000);
        send(4'b0100, 64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 4'b0000, 4'b1000);
        send(4'b0101, 64'd0, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 4'b1000);
        send(4'b0110, 64'hFF, 64'h0F, 1'b0, 1'b1, 64'h0F, 4'b0000, 4'b0000);
        send(4'b0111, 64'd5, 64'd5, 1'b0, 1'b1, 64'd0, 4'b0100, 4'b0100);
        send(4'b1000, 64'h8000_0000_0000_0003, 64'd1, 1'b0, 1'b1, 64'd6, 4'b0010, 4'b0010);
        send(4'b1001, 64'd3, 64'hFF00_0000_0000_0002, 1'b0, 1'b1, 64'd0, 4'b0110, 4'b0110);
        send(4'b1000, 64'h1234, 64'h40, 1'b0, 1'b1, 64'h1234, 4'b0000, 4'b0000);
        send(4'b1101, 64'd1, 64'hDEAD, 1'b0, 1'b1, 64'hDEAD, 4'b0000, 4'b0000);
        send(4'b1110, 64'd1, 64'd1, 1'b0, 1'b1, 64'd0, 4'b0100, 4'b0100);
        send(4'b1111, 64'd1, 64'd1, 1'b0, 1'b0, 64'd0, 4'b0000, 4'b0100);
        send(4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b1000);
        send(4'b1010, 64'h10, 64'd4, 1'b0, 1'b1, 64'd1, 4'b0000, 4'b0000);
        chk("stream_stall_cycles", 128'(stall_cnt), 128'd0);
        wait_drain();

        // Backpressure: two ops fill the pipe, the third waits.
        @(negedge clk);
        out_ready = 1'b0;
        send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'd0, 4'b0110, 4'b0110);
        send(4'b1011, 64'd1, 64'd1, 1'b0, 1'b1, 64'd3, 4'b0000, 4'b0000);
        in_valid = 1'b1;
        S        = 4'b0110;
        a        = 64'd3;
        b        = 64'd6;
        flags_en = 1'b0;
        #1;
        chk("full_in_ready_0", in_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("full_in_ready_1", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        send(4'b0110, 64'd3, 64'd6, 1'b0, 1'b0, 64'd2, 4'b0000, 4'b0000);
        wait_drain();

        // Reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0;
        send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'd0, 4'b0110, 4'b0110);
        send(4'b0111, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 4'b0100, 4'b0100);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("midreset_out_valid", out_valid, 1'b0);
        chk("midreset_nzcv", nzcv, 4'b0000);
        chk("midreset_in_ready", in_ready, 1'b0);
        chk("midreset_d", d, '0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        send(4'b0101, 64'd0, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b1000);
        wait_drain();
        repeat (3) @(negedge clk);
        #1;
        chk("idle_out_valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
